// File: rtl/pwm_pkg.sv
// Shared types and constants for the DPWM run-time sequencer.
// Holds the state encoding, the duty width and the frequency code table.
package pwm_pkg;

    localparam int DUTY_W  = 10;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_SOFT   = 3'd1,
        ST_RUN    = 3'd2,
        ST_RAMPDN = 3'd3,
        ST_FAULT  = 3'd4
    } pwm_state_e;

    localparam logic [3:0] FREQ_50K  = 4'b0000;
    localparam logic [3:0] FREQ_75K  = 4'b0001;
    localparam logic [3:0] FREQ_90K  = 4'b0010;
    localparam logic [3:0] FREQ_100K = 4'b0011;
    localparam logic [3:0] FREQ_115K = 4'b0100;
    localparam logic [3:0] FREQ_125K = 4'b0101;
    localparam logic [3:0] FREQ_140K = 4'b0110;
    localparam logic [3:0] FREQ_160K = 4'b0111;
    localparam logic [3:0] FREQ_180K = 4'b1000;
    localparam logic [3:0] FREQ_200K = 4'b1001;
    localparam logic [3:0] FREQ_250K = 4'b1010;

    // DPWM counter maxcount for each frequency code at a 50 MHz clock.
    function automatic int unsigned freq_maxcount(input logic [3:0] code);
        case (code)
            FREQ_50K:  return 1000;
            FREQ_75K:  return 667;
            FREQ_90K:  return 556;
            FREQ_100K: return 500;
            FREQ_115K: return 435;
            FREQ_125K: return 400;
            FREQ_140K: return 357;
            FREQ_160K: return 313;
            FREQ_180K: return 278;
            FREQ_200K: return 250;
            FREQ_250K: return 200;
            default:   return 357;
        endcase
    endfunction

endpackage

// File: rtl/pwm_sequencer_if.sv
// Control/status bundle between the supervisor and the DPWM sequencer.
// master drives requests and the DPWM period strobe; slave is the sequencer.
interface pwm_sequencer_if;
    import pwm_pkg::*;

    logic                start;
    logic                stop;
    logic                fault_in;
    logic                clear_fault;
    logic                period_end;
    logic [DUTY_W-1:0]   duty_target;
    logic [3:0]          freq_sel;
    logic                en;
    logic [DUTY_W-1:0]   duty_cmd;
    logic [3:0]          freq_cmd;
    logic [STATE_W-1:0]  state;
    logic                fault_latched;
    logic                at_target;

    modport master (
        output start, stop, fault_in, clear_fault, period_end, duty_target, freq_sel,
        input  en, duty_cmd, freq_cmd, state, fault_latched, at_target
    );

    modport slave (
        input  start, stop, fault_in, clear_fault, period_end, duty_target, freq_sel,
        output en, duty_cmd, freq_cmd, state, fault_latched, at_target
    );

endinterface

// File: rtl/pwm_ramp_tick.sv
// Prescales DPWM period_end pulses into a one-clk ramp tick every RAMP_DIV periods.
// A synchronous clear wins over a coincident period_end so that pulse is not counted.
module pwm_ramp_tick #(
    parameter int RAMP_DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic period_end,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(RAMP_DIV - 1);

    logic [7:0] cnt_reg;

    assign tick = period_end && !clr && (cnt_reg == LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (period_end) begin
            cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 8'd1;
        end
    end

endmodule

// File: rtl/pwm_sequencer.sv
// DPWM run-time sequencer: soft-start, slew-limited tracking, ramp-down and latched
// fault shutdown; duty changes land only on ramp ticks derived from period_end.
module pwm_sequencer #(
    parameter int         DUTY_W     = pwm_pkg::DUTY_W,
    parameter int         RAMP_STEP  = 1,
    parameter int         RAMP_DIV   = 4,
    parameter int         DUTY_MAX   = 900,
    parameter int         FAULT_HOLD = 1024,
    parameter logic [3:0] FREQ_RST   = pwm_pkg::FREQ_140K
) (
    input  logic          clk,
    input  logic          resetn,
    pwm_sequencer_if.slave bus
);
    import pwm_pkg::*;

    localparam int DW1    = DUTY_W + 1;
    localparam int HOLD_W = $clog2(FAULT_HOLD + 1);

    localparam logic [DW1-1:0]     DMAX     = DW1'(DUTY_MAX);
    localparam logic [DW1-1:0]     STEP     = DW1'(RAMP_STEP);
    localparam logic [HOLD_W-1:0]  HOLD_END = HOLD_W'(FAULT_HOLD);

    localparam logic [STATE_W-1:0] IDLE   = ST_IDLE;
    localparam logic [STATE_W-1:0] SOFT   = ST_SOFT;
    localparam logic [STATE_W-1:0] RUN    = ST_RUN;
    localparam logic [STATE_W-1:0] RAMPDN = ST_RAMPDN;
    localparam logic [STATE_W-1:0] FAULT  = ST_FAULT;

    logic [STATE_W-1:0] state_reg, state_next;
    logic [DUTY_W-1:0]  duty_reg, duty_next;
    logic [3:0]         freq_reg, freq_next;
    logic [HOLD_W-1:0]  hold_reg, hold_next;
    logic               en_reg, en_next;

    logic [DW1-1:0] duty_ext, tgt, soft_sum, soft_next, run_next, dn_next;
    logic           tick, evt_change, hold_done;

    // Widened by one bit so step arithmetic and compares never wrap.
    assign duty_ext  = {1'b0, duty_reg};
    assign tgt       = ({1'b0, bus.duty_target} > DMAX) ? DMAX : {1'b0, bus.duty_target};
    assign soft_sum  = duty_ext + STEP;
    assign soft_next = (soft_sum > tgt) ? tgt : soft_sum;
    assign dn_next   = (duty_ext > STEP) ? duty_ext - STEP : '0;
    assign hold_done = (hold_reg == HOLD_END);

    always_comb begin
        run_next = tgt;
        if (duty_ext < tgt) begin
            run_next = ((tgt - duty_ext) > STEP) ? duty_ext + STEP : tgt;
        end else if (duty_ext > tgt) begin
            run_next = ((duty_ext - tgt) > STEP) ? duty_ext - STEP : tgt;
        end
    end

    // Request-driven transitions; kept free of tick so the prescaler clear has no loop.
    assign evt_change = (bus.fault_in && (state_reg != FAULT))
                     || ((state_reg == IDLE) && bus.start && !bus.stop)
                     || (((state_reg == SOFT) || (state_reg == RUN)) && bus.stop)
                     || ((state_reg == FAULT) && !bus.fault_in && hold_done && bus.clear_fault);

    pwm_ramp_tick #(
        .RAMP_DIV(RAMP_DIV)
    ) u_ramp_tick (
        .clk        (clk),
        .resetn     (resetn),
        .clr        (evt_change),
        .period_end (bus.period_end),
        .tick       (tick)
    );

    always_comb begin
        state_next = state_reg;
        duty_next  = duty_reg;
        freq_next  = freq_reg;
        hold_next  = hold_reg;
        if (bus.fault_in && (state_reg != FAULT)) begin
            state_next = FAULT;
            duty_next  = '0;
            hold_next  = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    duty_next = '0;
                    if (bus.start && !bus.stop) begin
                        state_next = SOFT;
                        freq_next  = bus.freq_sel;
                    end
                end
                SOFT: begin
                    if (bus.stop) begin
                        state_next = RAMPDN;
                    end else if (tick) begin
                        duty_next = soft_next[DUTY_W-1:0];
                        if (soft_next == tgt) state_next = RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_next = RAMPDN;
                    end else if (tick) begin
                        duty_next = run_next[DUTY_W-1:0];
                    end
                end
                RAMPDN: begin
                    if (tick) begin
                        duty_next = dn_next[DUTY_W-1:0];
                        if (dn_next == '0) state_next = IDLE;
                    end
                end
                FAULT: begin
                    duty_next = '0;
                    if (bus.fault_in) begin
                        hold_next = '0;
                    end else if (hold_done && bus.clear_fault) begin
                        state_next = IDLE;
                    end else if (!hold_done) begin
                        hold_next = hold_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    duty_next  = '0;
                end
            endcase
        end
    end

    assign en_next = (state_next == SOFT) || (state_next == RUN) || (state_next == RAMPDN);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            duty_reg  <= '0;
            freq_reg  <= FREQ_RST;
            hold_reg  <= '0;
            en_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            duty_reg  <= duty_next;
            freq_reg  <= freq_next;
            hold_reg  <= hold_next;
            en_reg    <= en_next;
        end
    end

    assign bus.en            = en_reg;
    assign bus.duty_cmd      = duty_reg;
    assign bus.freq_cmd      = freq_reg;
    assign bus.state         = state_reg;
    assign bus.fault_latched = (state_reg == FAULT);
    assign bus.at_target     = (state_reg == RUN) && (duty_ext == tgt);

endmodule

// File: doc/pwm_sequencer.md
Name: pwm_sequencer

Overview:
- Run-time controller for the DPWM power stage; drives the DPWM enable, the applied duty count and the latched frequency code.
- Sequences IDLE -> soft-start ramp -> RUN -> ramp-down, with slew-limited duty tracking.
- Provides latched fault shutdown.
- All duty/frequency updates are applied only at DPWM period boundaries, so no mid-period glitch reaches the gate drive.

Parameters:
- DUTY_W, 10, width of duty counts (matches DPWM maxcount width)
- RAMP_STEP, 1, duty count increment/decrement per ramp tick
- RAMP_DIV, 4, DPWM periods per ramp tick (1..255)
- DUTY_MAX, 900, clamp on any applied duty count
- FAULT_HOLD, 1024, minimum clk cycles spent in FAULT before clear is accepted
- FREQ_RST, 4'b0110, frequency code after reset (140 kHz)

Ports:
- clk, in, 1, system clock (50 MHz)
- resetn, in, 1, asynchronous active-low reset
- start, in, 1, level-sampled start request
- stop, in, 1, level-sampled stop request
- fault_in, in, 1, synchronous fault flag (overcurrent/overvoltage comparator)
- clear_fault, in, 1, fault acknowledge
- period_end, in, 1, one-clk pulse from DPWM on counter wrap
- duty_target, in, DUTY_W, requested steady-state duty count
- freq_sel, in, 4, requested frequency code
- en, out, 1, DPWM enable
- duty_cmd, out, DUTY_W, applied duty count to DPWM
- freq_cmd, out, 4, applied frequency code
- state, out, 3, current state encoding
- fault_latched, out, 1, high while in FAULT
- at_target, out, 1, high in RUN when duty_cmd == clamped target

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on resetn.
- Reset values: en=0, duty_cmd=0, freq_cmd=FREQ_RST, state=IDLE, fault_latched=0, at_target=0; internal tick and hold counters cleared.
- Clamped target: tgt = min(duty_target, DUTY_MAX), recomputed every cycle.
- Ramp tick: a period counter counts period_end pulses and generates a tick on every RAMP_DIV-th pulse. It is cleared on any state change.
- State encoding: IDLE=0, SOFT=1, RUN=2, RAMPDN=3, FAULT=4.
- IDLE:
  - en=0, duty_cmd=0.
  - When start=1 and stop=0 and fault_in=0: freq_cmd <= freq_sel, go to SOFT. en=1 from the next cycle.
- SOFT:
  - On each tick: duty_cmd <= min(duty_cmd+RAMP_STEP, tgt), saturating with no overshoot.
  - When duty_cmd == tgt after a tick, go to RUN.
  - If tgt==0, go to RUN on the first tick.
- RUN:
  - Tracks tgt with slew limiting: on each tick, step up or down by at most RAMP_STEP toward tgt.
  - at_target=1 when duty_cmd==tgt.
  - freq_sel is ignored while not in IDLE; the frequency changes only via stop/start.
- RAMPDN:
  - Entered from SOFT or RUN when stop=1.
  - On each tick: duty_cmd <= duty_cmd - min(RAMP_STEP, duty_cmd), saturating at 0.
  - At duty_cmd==0, go to IDLE on that same tick; en drops the cycle after.
  - start is ignored in RAMPDN.
- FAULT:
  - fault_in=1 in any state other than FAULT means: next edge en=0, duty_cmd=0, state=FAULT, fault_latched=1. Latency is 1 clk and is not gated by period_end.
  - The hold counter counts up to FAULT_HOLD.
  - Exit to IDLE only when hold expired, fault_in=0 and clear_fault=1 in the same cycle. A clear_fault arriving earlier is ignored and is not remembered.
  - fault_in re-asserting during FAULT restarts the hold counter.
- Priority per cycle: fault_in > stop > start > ramp tick.
- period_end arriving together with a state transition: the transition wins and no tick is counted.
- Width rules: all duty arithmetic is unsigned DUTY_W+1 bits internally, so the compare never wraps. DUTY_MAX must be less than 2^DUTY_W.
- Reset mid-ramp: outputs return to their reset values asynchronously.

Decomposition:
- Shared package pwm_pkg holds:
  - state enum (IDLE..FAULT) and its 3-bit width
  - FREQ codes 4'b0000..4'b1010 with their maxcount constants
  - DUTY_W
- One natural sub-module, pwm_ramp_tick: period_end prescaler with synchronous clear, producing the one-clk tick.
- FSM and the saturating ramp arithmetic stay in pwm_sequencer.

Test Plan:
- Reset, then start=1 with freq_sel=4'b0110 and duty_target=150, RAMP_DIV=4, period_end every 357 clk: freq_cmd=4'b0110, en=1 one cycle later, duty_cmd steps 0->1->...->150, one step per 4 periods. RUN is reached after 600 periods and at_target=1.
- In RUN, change duty_target 150->140: duty_cmd reaches 140 after 10 ticks with no overshoot. Set duty_target=1000: duty_cmd clamps at 900.
- In RUN at duty 150, assert stop: ramps down to 0 in 150 ticks, then IDLE and en=0 the following cycle. start asserted mid-ramp has no effect.
- Assert fault_in at duty 80 mid-period: next edge en=0, duty_cmd=0, fault_latched=1. clear_fault at hold cycle 500 is ignored. clear_fault at cycle 1024 with fault_in=0 returns to IDLE.
- Assert fault_in and stop in the same cycle during SOFT: FAULT is entered, not RAMPDN. Assert start and stop together in IDLE: stays in IDLE.
- Deassert resetn mid-SOFT at duty 40: all outputs return to their reset values immediately (asynchronously). After release, a new start ramps again from 0.
